// File: rtl/sample_pkg.sv
// Shared definitions for the UART-byte to audio-sample packing path.
package sample_pkg;

  localparam int BPS_DEFAULT     = 24;
  localparam int TIMEOUT_DEFAULT = 4096;
  localparam int CNT_W_DEFAULT   = 16;

  // Packer control states: waiting for byte 0, gathering the rest, publishing.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2
  } state_t;

  // Number of UART bytes that make up one sample.
  function automatic int nbytes(input int bps);
    return bps / 8;
  endfunction

endpackage

// File: rtl/uart_sample_packer_inter_byte_timer.sv
// Idle-cycle counter between received bytes; flags when the allowed gap is used up.
module inter_byte_timer #(
  parameter int LIMIT = 4096
) (
  input  logic in_clk,
  input  logic in_reset,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expire
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] r_count;

  // Count idle cycles; a clear always restarts the window, expiry holds the value.
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count && !o_expire) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expire = (r_count == W'(LIMIT - 1));

endmodule

// File: rtl/uart_sample_packer.sv
// Packs consecutive UART bytes (MSB byte first) into BPS-bit samples, with a
// one-cycle ready pulse per sample and an inter-byte timeout that drops a
// partial sample so byte alignment recovers after a lost byte.
module uart_sample_packer
  import sample_pkg::*;
#(
  parameter int BPS          = BPS_DEFAULT,
  parameter int TIMEOUT_CLKS = TIMEOUT_DEFAULT,
  parameter int CNT_W        = CNT_W_DEFAULT
) (
  input  logic             in_clk,
  input  logic             in_reset,
  input  logic             in_uart_ready,
  input  logic [7:0]       in_uart_frame,
  output logic [BPS-1:0]   out_frame,
  output logic             out_ready,
  output logic             out_timeout_err,
  output logic [CNT_W-1:0] out_sample_count
);

  localparam int NBYTES = nbytes(BPS);
  localparam int IDX_W  = $clog2(NBYTES + 1);

  if ((BPS % 8) != 0 || BPS < 8 || BPS > 32) begin : g_bad_bps
    $error("uart_sample_packer: BPS must be a multiple of 8 between 8 and 32");
  end
  if (TIMEOUT_CLKS < 2) begin : g_bad_timeout
    $error("uart_sample_packer: TIMEOUT_CLKS must be at least 2");
  end

  state_t             r_state;
  logic [IDX_W-1:0]   r_index;
  logic [BPS-1:0]     r_shift;
  logic [BPS-1:0]     r_frame;
  logic               r_ready;
  logic               r_timeout_err;
  logic [CNT_W-1:0]   r_count;

  logic               w_expire;
  logic               w_timer_clear;
  logic               w_timer_count;

  // The gap timer only runs while a sample is partially collected; any byte restarts it.
  assign w_timer_count = (r_state == ST_COLLECT);
  assign w_timer_clear = in_uart_ready || (r_state != ST_COLLECT);

  inter_byte_timer #(
    .LIMIT (TIMEOUT_CLKS)
  ) u_timer (
    .in_clk   (in_clk),
    .in_reset (in_reset),
    .i_clear  (w_timer_clear),
    .i_count  (w_timer_count),
    .o_expire (w_expire)
  );

  // Packing FSM with registered outputs; a byte beats a simultaneous timeout.
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      r_state       <= ST_IDLE;
      r_index       <= '0;
      r_shift       <= '0;
      r_frame       <= '0;
      r_ready       <= 1'b0;
      r_timeout_err <= 1'b0;
      r_count       <= '0;
    end else begin
      r_ready       <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        ST_IDLE, ST_EMIT: begin
          // NOTE: non-blocking updates mean EMIT publishes the pre-edge shift
          // register even when a new byte 0 is loaded into it on the same edge.
          if (r_state == ST_EMIT) begin
            r_frame <= r_shift;
            r_ready <= 1'b1;
            r_count <= r_count + 1'b1;
          end
          if (in_uart_ready) begin
            r_shift <= BPS'(in_uart_frame) << (BPS - 8);
            r_index <= IDX_W'(1);
            r_state <= (NBYTES == 1) ? ST_EMIT : ST_COLLECT;
          end else begin
            r_index <= '0;
            r_state <= ST_IDLE;
          end
        end
        ST_COLLECT: begin
          if (in_uart_ready) begin
            r_shift[BPS - 8 - 8 * int'(r_index) +: 8] <= in_uart_frame;
            r_index <= r_index + 1'b1;
            if (r_index == IDX_W'(NBYTES - 1)) begin
              r_state <= ST_EMIT;
            end
          end else if (w_expire) begin
            r_shift       <= '0;
            r_index       <= '0;
            r_timeout_err <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end
        default: begin
          r_index <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_frame        = r_frame;
  assign out_ready        = r_ready;
  assign out_timeout_err  = r_timeout_err;
  assign out_sample_count = r_count;

endmodule

// File: tb/tb_uart_sample_packer.sv
// Bench for uart_sample_packer: a 24-bit build with the default timeout and a
// 16-bit build with a short timeout and an 8-bit counter (to reach the wrap).
module tb_uart_sample_packer;

  localparam int TO_A = 4096;
  localparam int TO_B = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, rst_b = 1'b1;
  logic        rdy_a = 1'b0, rdy_b = 1'b0;
  logic [7:0]  byte_a = '0, byte_b = '0;
  logic [23:0] frame_a;
  logic [15:0] frame_b;
  logic        ready_a, ready_b, err_a, err_b;
  logic [15:0] cnt_a;
  logic [7:0]  cnt_b;

  uart_sample_packer #(.BPS(24), .TIMEOUT_CLKS(TO_A), .CNT_W(16)) dut_a (
    .in_clk           (clk),
    .in_reset         (rst_a),
    .in_uart_ready    (rdy_a),
    .in_uart_frame    (byte_a),
    .out_frame        (frame_a),
    .out_ready        (ready_a),
    .out_timeout_err  (err_a),
    .out_sample_count (cnt_a)
  );

  uart_sample_packer #(.BPS(16), .TIMEOUT_CLKS(TO_B), .CNT_W(8)) dut_b (
    .in_clk           (clk),
    .in_reset         (rst_b),
    .in_uart_ready    (rdy_b),
    .in_uart_frame    (byte_b),
    .out_frame        (frame_b),
    .out_ready        (ready_b),
    .out_timeout_err  (err_b),
    .out_sample_count (cnt_b)
  );

  // Cycle number; read on falling edges by both the driver and the monitor.
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: bytes are grouped into samples in arrival order; a sample
  // in progress is dropped (with an error TIMEOUT cycles after its last byte)
  // when the next byte arrives more than TIMEOUT cycles later.
  int          sel;
  int          m_nb, m_to;
  longint      m_mask;
  logic [7:0]  m_part[$];
  longint      m_last;
  longint      m_count;
  logic [31:0] m_frame;

  longint      exp_rt[$], got_rt[$], exp_et[$], got_et[$];
  logic [31:0] exp_rf[$], got_rf[$];

  // Records every ready / timeout pulse of the DUT under test with its cycle.
  always @(negedge clk) begin
    if (sel == 0) begin
      if (ready_a) begin got_rt.push_back(cyc); got_rf.push_back(32'(frame_a)); end
      if (err_a) got_et.push_back(cyc);
    end else begin
      if (ready_b) begin got_rt.push_back(cyc); got_rf.push_back(32'(frame_b)); end
      if (err_b) got_et.push_back(cyc);
    end
  end

  function automatic logic [31:0] cur_frame();
    return (sel == 0) ? 32'(frame_a) : 32'(frame_b);
  endfunction

  function automatic logic [31:0] cur_count();
    return (sel == 0) ? 32'(cnt_a) : 32'(cnt_b);
  endfunction

  task automatic select_dut(input int s);
    sel    = s;
    m_nb   = (s == 0) ? 3 : 2;
    m_to   = (s == 0) ? TO_A : TO_B;
    m_mask = (s == 0) ? 64'hFFFF : 64'hFF;
  endtask

  task automatic model_reset();
    m_part.delete();
    m_count = 0;
    m_frame = '0;
    m_last  = 0;
  endtask

  task automatic clear_events();
    exp_rt.delete(); exp_rf.delete(); exp_et.delete();
    got_rt.delete(); got_rf.delete(); got_et.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, input longint t);
    logic [31:0] f;
    if (m_part.size() > 0 && (t - m_last) > m_to) begin
      exp_et.push_back(m_last + m_to);
      m_part.delete();
    end
    m_part.push_back(b);
    m_last = t;
    if (m_part.size() == m_nb) begin
      f = '0;
      foreach (m_part[i]) f = (f << 8) | 32'(m_part[i]);
      exp_rt.push_back(t + 1);
      exp_rf.push_back(f);
      m_frame = f;
      m_count++;
      m_part.delete();
    end
  endtask

  // One strobed byte, starting and ending on a falling edge.
  task automatic send(input logic [7:0] b);
    if (sel == 0) begin rdy_a = 1'b1; byte_a = b; end
    else          begin rdy_b = 1'b1; byte_b = b; end
    @(negedge clk);
    model_byte(b, cyc);
    rdy_a  = 1'b0;
    rdy_b  = 1'b0;
    byte_a = 8'($urandom);
    byte_b = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Lets any pending sample complete or time out before results are compared.
  task automatic settle();
    if (m_part.size() > 0) begin
      idle(m_to + 4);
      exp_et.push_back(m_last + m_to);
      m_part.delete();
    end else begin
      idle(4);
    end
  endtask

  task automatic test_reset();
    idle(3);
    n_checks++;
    if ({frame_a, ready_a, err_a, cnt_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_a_held: frame %h ready %b err %b count %h, expected all zero",
               frame_a, ready_a, err_a, cnt_a);
    end
    n_checks++;
    if ({frame_b, ready_b, err_b, cnt_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_b_held: frame %h ready %b err %b count %h, expected all zero",
               frame_b, ready_b, err_b, cnt_b);
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    idle(3);
    n_checks++;
    if ({frame_a, ready_a, err_a, cnt_a, frame_b, ready_b, err_b, cnt_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_released: a frame %h cnt %h, b frame %h cnt %h, expected zero",
               frame_a, cnt_a, frame_b, cnt_b);
    end
  endtask

  task automatic test_basic();
    clear_events();
    send(8'h12); idle(1069);
    send(8'h34); idle(1069);
    send(8'h56);
    n_checks++;
    if (exp_rf.size() != 1 || exp_rf[0] !== 32'h0012_3456) begin
      n_fail++;
      $display("FAIL basic_model: model produced %0d samples, expected one 123456", exp_rf.size());
    end
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 3; k++) begin
        idle($urandom_range(0, 40));
        send(8'($urandom));
      end
    end
    settle();
    n_checks++;
    if (got_rt.size() != exp_rt.size() || got_et.size() != exp_et.size()) begin
      n_fail++;
      $display("FAIL basic_events: got %0d ready/%0d err, expected %0d ready/%0d err",
               got_rt.size(), got_et.size(), exp_rt.size(), exp_et.size());
    end
    for (int i = 0; i < exp_rt.size() && i < got_rt.size(); i++) begin
      n_checks++;
      if (got_rt[i] != exp_rt[i] || got_rf[i] !== exp_rf[i]) begin
        n_fail++;
        $display("FAIL basic_sample %0d: cycle %0d frame %h, expected cycle %0d frame %h",
                 i, got_rt[i], got_rf[i], exp_rt[i], exp_rf[i]);
      end
    end
    n_checks++;
    if (cur_count() != 32'(m_count & m_mask) || cur_frame() !== m_frame) begin
      n_fail++;
      $display("FAIL basic_final: count %0d frame %h, expected count %0d frame %h",
               cur_count(), cur_frame(), m_count & m_mask, m_frame);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] held;
    clear_events();
    model_reset();
    rst_a = 1'b1; idle(2); rst_a = 1'b0; idle(2);
    held = m_frame;
    send(8'hAA); idle(3);
    send(8'hBB); idle(4200);
    n_checks++;
    if (cur_frame() !== held) begin
      n_fail++;
      $display("FAIL timeout_frame_held: frame %h, expected %h", cur_frame(), held);
    end
    idle(5000 - 4200);
    send(8'h01); send(8'h02); send(8'h03);
    settle();
    n_checks++;
    if (got_rt.size() != 1 || got_et.size() != 1 || exp_et.size() != 1) begin
      n_fail++;
      $display("FAIL timeout_events: got %0d ready/%0d err, expected 1 ready/1 err",
               got_rt.size(), got_et.size());
    end
    for (int i = 0; i < exp_et.size() && i < got_et.size(); i++) begin
      n_checks++;
      if (got_et[i] != exp_et[i]) begin
        n_fail++;
        $display("FAIL timeout_err %0d: cycle %0d, expected %0d", i, got_et[i], exp_et[i]);
      end
    end
    n_checks++;
    if (cur_frame() !== 32'h0001_0203 || cur_count() != 32'd1) begin
      n_fail++;
      $display("FAIL timeout_recover: frame %h count %0d, expected 010203 count 1",
               cur_frame(), cur_count());
    end
  endtask

  task automatic test_back_to_back();
    clear_events();
    for (int i = 0; i < 6; i++) send(8'h0A + 8'(i));
    settle();
    n_checks++;
    if (got_rt.size() != 2 || got_et.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_events: got %0d ready/%0d err, expected 2 ready/0 err",
               got_rt.size(), got_et.size());
    end
    for (int i = 0; i < exp_rt.size() && i < got_rt.size(); i++) begin
      n_checks++;
      if (got_rt[i] != exp_rt[i] || got_rf[i] !== exp_rf[i]) begin
        n_fail++;
        $display("FAIL b2b_sample %0d: cycle %0d frame %h, expected cycle %0d frame %h",
                 i, got_rt[i], got_rf[i], exp_rt[i], exp_rf[i]);
      end
    end
    n_checks++;
    if (cur_frame() !== 32'h000D_0E0F || cur_count() != 32'(m_count & m_mask)) begin
      n_fail++;
      $display("FAIL b2b_final: frame %h count %0d, expected 0d0e0f count %0d",
               cur_frame(), cur_count(), m_count & m_mask);
    end
  endtask

  task automatic test_expiry_boundary();
    clear_events();
    // Gaps of TIMEOUT-1 idle cycles land the byte on the expiry cycle: accepted.
    send(8'hA1); idle(m_to - 1);
    send(8'hA2); idle(m_to - 1);
    send(8'hA3);
    // One more idle cycle and the partial sample is gone.
    send(8'hB1); idle(m_to);
    send(8'hB2); send(8'hB3); send(8'hB4);
    settle();
    n_checks++;
    if (got_rt.size() != exp_rt.size() || got_et.size() != exp_et.size()) begin
      n_fail++;
      $display("FAIL boundary_events: got %0d ready/%0d err, expected %0d ready/%0d err",
               got_rt.size(), got_et.size(), exp_rt.size(), exp_et.size());
    end
    for (int i = 0; i < exp_rt.size() && i < got_rt.size(); i++) begin
      n_checks++;
      if (got_rt[i] != exp_rt[i] || got_rf[i] !== exp_rf[i]) begin
        n_fail++;
        $display("FAIL boundary_sample %0d: cycle %0d frame %h, expected cycle %0d frame %h",
                 i, got_rt[i], got_rf[i], exp_rt[i], exp_rf[i]);
      end
    end
    for (int i = 0; i < exp_et.size() && i < got_et.size(); i++) begin
      n_checks++;
      if (got_et[i] != exp_et[i]) begin
        n_fail++;
        $display("FAIL boundary_err %0d: cycle %0d, expected %0d", i, got_et[i], exp_et[i]);
      end
    end
  endtask

  task automatic test_random_gaps();
    int r, gap;
    clear_events();
    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       gap = $urandom_range(0, 20);
      else if (r == 6) gap = m_to - 2;
      else if (r == 7) gap = m_to - 1;
      else if (r == 8) gap = m_to;
      else             gap = m_to + $urandom_range(0, 50);
      idle(gap);
      send(8'($urandom));
    end
    settle();
    n_checks++;
    if (got_rt.size() != exp_rt.size() || got_et.size() != exp_et.size()) begin
      n_fail++;
      $display("FAIL random_events: got %0d ready/%0d err, expected %0d ready/%0d err",
               got_rt.size(), got_et.size(), exp_rt.size(), exp_et.size());
    end
    for (int i = 0; i < exp_rt.size() && i < got_rt.size(); i++) begin
      n_checks++;
      if (got_rt[i] != exp_rt[i] || got_rf[i] !== exp_rf[i]) begin
        n_fail++;
        $display("FAIL random_sample %0d: cycle %0d frame %h, expected cycle %0d frame %h",
                 i, got_rt[i], got_rf[i], exp_rt[i], exp_rf[i]);
      end
    end
    for (int i = 0; i < exp_et.size() && i < got_et.size(); i++) begin
      n_checks++;
      if (got_et[i] != exp_et[i]) begin
        n_fail++;
        $display("FAIL random_err %0d: cycle %0d, expected %0d", i, got_et[i], exp_et[i]);
      end
    end
    n_checks++;
    if (cur_count() != 32'(m_count & m_mask) || cur_frame() !== m_frame) begin
      n_fail++;
      $display("FAIL random_final: count %0d frame %h, expected count %0d frame %h",
               cur_count(), cur_frame(), m_count & m_mask, m_frame);
    end
  endtask

  task automatic test_reset_mid_sample();
    clear_events();
    send(8'h11); idle(2);
    send(8'h22); idle(2);
    rst_a = 1'b1;
    idle(1);
    n_checks++;
    if (frame_a !== '0 || err_a !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_during: frame %h err %b, expected 000000 err 0", frame_a, err_a);
    end
    idle(2);
    rst_a = 1'b0;
    model_reset();
    idle(m_to + 10);
    n_checks++;
    if (frame_a !== '0 || cnt_a !== '0 || got_et.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_after: frame %h count %0d err pulses %0d, expected 0/0/0",
               frame_a, cnt_a, got_et.size());
    end
    send(8'h77); idle(5);
    send(8'h88); idle(5);
    send(8'h99);
    settle();
    n_checks++;
    if (got_rt.size() != 1 || got_et.size() != 0 || cur_frame() !== 32'h0077_8899
        || cur_count() != 32'd1) begin
      n_fail++;
      $display("FAIL midreset_resume: %0d ready/%0d err frame %h count %0d, expected 1/0 778899 1",
               got_rt.size(), got_et.size(), cur_frame(), cur_count());
    end
  endtask

  task automatic test_bps16_wrap();
    select_dut(1);
    model_reset();
    rst_b = 1'b1; idle(2); rst_b = 1'b0; idle(2);
    clear_events();
    send(8'hFE); idle(3);
    send(8'hDC); idle(3);
    n_checks++;
    if (frame_b !== 16'hFEDC || cnt_b !== 8'd1) begin
      n_fail++;
      $display("FAIL bps16_sample: frame %h count %0d, expected fedc count 1", frame_b, cnt_b);
    end
    // A lone byte left to time out with the short timeout.
    send(8'h5A);
    settle();
    for (int s = 0; s < 255; s++) begin
      send(8'($urandom));
      send(8'($urandom));
    end
    settle();
    n_checks++;
    if (got_rt.size() != exp_rt.size() || got_et.size() != exp_et.size()) begin
      n_fail++;
      $display("FAIL bps16_events: got %0d ready/%0d err, expected %0d ready/%0d err",
               got_rt.size(), got_et.size(), exp_rt.size(), exp_et.size());
    end
    for (int i = 0; i < exp_rt.size() && i < got_rt.size(); i++) begin
      n_checks++;
      if (got_rt[i] != exp_rt[i] || got_rf[i] !== exp_rf[i]) begin
        n_fail++;
        $display("FAIL bps16_sample %0d: cycle %0d frame %h, expected cycle %0d frame %h",
                 i, got_rt[i], got_rf[i], exp_rt[i], exp_rf[i]);
      end
    end
    for (int i = 0; i < exp_et.size() && i < got_et.size(); i++) begin
      n_checks++;
      if (got_et[i] != exp_et[i]) begin
        n_fail++;
        $display("FAIL bps16_err %0d: cycle %0d, expected %0d", i, got_et[i], exp_et[i]);
      end
    end
    n_checks++;
    if (cnt_b !== 8'(m_count & m_mask) || m_count != 256) begin
      n_fail++;
      $display("FAIL bps16_wrap: count %0d after %0d samples, expected %0d",
               cnt_b, m_count, m_count & m_mask);
    end
  endtask

  initial begin
    select_dut(0);
    model_reset();
    test_reset();
    test_basic();
    test_timeout();
    test_back_to_back();
    test_expiry_boundary();
    test_random_gaps();
    test_reset_mid_sample();
    test_bps16_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
